rtc_multi_alarm: RTL and testbench

- Parametrised successor of the single-alarm time block: 24-hour real-time clock with N independent alarm channels, per-channel enable, snooze and auto-timeout of ringing.
- Sits between the debounced button/switch front end and the 7-segment display mux; drives displayed time, selected-alarm readout and per-channel ring flags to the buzzer driver.
- Set modes freeze the running time, so there is no race between adjustment and seconds rollover.

---
 rtl/rtc_multi_alarm.sv | 204 ++++++++++++++++++++
 tb/tb_rtc_multi_alarm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_multi_alarm.sv
// 24-hour real-time clock with N independent alarm channels, per-channel enable,
// snooze and auto-timeout of ringing. Set modes freeze time; alarm edit keeps it running.
module rtc_multi_alarm #(
  parameter int TICK_DIV   = 1000000,
  parameter int N_ALARM    = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int AW         = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               inc,
  input  logic               dec,
  input  logic [AW-1:0]      sel,
  input  logic               field,
  input  logic               en_tgl,
  input  logic               snooze,
  input  logic               dismiss,
  output logic [4:0]         hour,
  output logic [5:0]         min,
  output logic [5:0]         sec,
  output logic [4:0]         alm_hour,
  output logic [5:0]         alm_min,
  output logic [N_ALARM-1:0] alm_en,
  output logic [N_ALARM-1:0] ringing,
  output logic               tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0]      r_div;
  logic               r_tick;
  logic               r_upd;
  logic [4:0]         r_hour;
  logic [5:0]         r_min;
  logic [5:0]         r_sec;
  logic [4:0]         r_ah   [N_ALARM];
  logic [5:0]         r_am   [N_ALARM];
  logic [4:0]         r_sh   [N_ALARM];
  logic [5:0]         r_sm   [N_ALARM];
  logic [7:0]         r_cnt  [N_ALARM];
  logic [N_ALARM-1:0] r_en;
  logic [N_ALARM-1:0] r_ring;
  logic [N_ALARM-1:0] r_pend;

  logic               w_adj;
  logic               w_set;
  logic [4:0]         w_sel_h;
  logic [5:0]         w_sel_m;
  logic [6:0]         w_msum;
  logic [4:0]         w_snz_h;
  logic [5:0]         w_snz_m;
  logic               w_at_min;
  logic [N_ALARM-1:0] w_shit;
  logic [N_ALARM-1:0] w_match;

  function automatic logic [4:0] f_wrap_h(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] f_wrap_m(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // Simultaneous inc and dec cancel out.
  assign w_adj    = inc ^ dec;
  assign w_set    = (mode == 2'b01) || (mode == 2'b10);
  assign w_at_min = r_upd && (r_sec == 6'd0);

  always_comb begin
    w_sel_h = '0;
    w_sel_m = '0;
    for (int k = 0; k < N_ALARM; k++) begin
      if (sel == AW'(k)) begin
        w_sel_h = r_ah[k];
        w_sel_m = r_am[k];
      end
    end
  end

  always_comb begin
    w_msum  = {1'b0, r_min} + 7'(SNOOZE_MIN);
    w_snz_h = r_hour;
    w_snz_m = w_msum[5:0];
    if (w_msum >= 7'd60) begin
      w_snz_m = w_msum[5:0] - 6'd60;
      w_snz_h = f_wrap_h(r_hour, 1'b1);
    end
  end

  always_comb begin
    w_shit  = '0;
    w_match = '0;
    for (int k = 0; k < N_ALARM; k++) begin
      w_shit[k]  = w_at_min && r_pend[k] && (r_sh[k] == r_hour) && (r_sm[k] == r_min);
      w_match[k] = w_at_min && r_en[k] && !r_ring[k] &&
                   (w_shit[k] || ((r_ah[k] == r_hour) && (r_am[k] == r_min)));
    end
  end

  // r_tick is raised together with the divider's last count, so the time
  // update lands on the edge that closes that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DW'(TICK_DIV - 2));
      r_div  <= r_tick ? '0 : r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hour <= '0;
      r_min  <= '0;
      r_sec  <= '0;
      r_upd  <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (w_set) begin
        r_sec <= '0;
        if (w_adj && (mode == 2'b01)) r_hour <= f_wrap_h(r_hour, inc);
        if (w_adj && (mode == 2'b10)) r_min  <= f_wrap_m(r_min, inc);
      end else if (r_tick) begin
        r_upd <= 1'b1;
        if (r_sec == 6'd59) begin
          r_sec <= '0;
          if (r_min == 6'd59) begin
            r_min  <= '0;
            r_hour <= f_wrap_h(r_hour, 1'b1);
          end else begin
            r_min <= r_min + 6'd1;
          end
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end
    end
  end

  // Per-channel state; within a cycle dismiss beats snooze, which beats a match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= '0;
      r_ring <= '0;
      r_pend <= '0;
      for (int k = 0; k < N_ALARM; k++) begin
        r_ah[k]  <= '0;
        r_am[k]  <= '0;
        r_sh[k]  <= '0;
        r_sm[k]  <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_ALARM; k++) begin
        if ((mode == 2'b11) && w_adj && (sel == AW'(k))) begin
          if (field) r_am[k] <= f_wrap_m(w_sel_m, inc);
          else       r_ah[k] <= f_wrap_h(w_sel_h, inc);
        end
        if (dismiss) begin
          r_ring[k] <= 1'b0;
          r_pend[k] <= 1'b0;
        end else if (snooze) begin
          if (r_ring[k]) begin
            r_ring[k] <= 1'b0;
            r_pend[k] <= 1'b1;
            r_sh[k]   <= w_snz_h;
            r_sm[k]   <= w_snz_m;
          end
        end else begin
          if (w_shit[k]) r_pend[k] <= 1'b0;
          if (w_match[k]) begin
            r_ring[k] <= 1'b1;
            r_cnt[k]  <= '0;
          end else if (r_ring[k] && r_tick) begin
            if (r_cnt[k] == 8'(RING_SEC - 1)) r_ring[k] <= 1'b0;
            else                              r_cnt[k]  <= r_cnt[k] + 8'd1;
          end
        end
        if (en_tgl && (sel == AW'(k))) begin
          r_en[k] <= !r_en[k];
          if (r_en[k]) begin
            r_ring[k] <= 1'b0;
            r_pend[k] <= 1'b0;
          end
        end
      end
    end
  end

  assign hour     = r_hour;
  assign min      = r_min;
  assign sec      = r_sec;
  assign alm_hour = w_sel_h;
  assign alm_min  = w_sel_m;
  assign alm_en   = r_en;
  assign ringing  = r_ring;
  assign tick     = r_tick;

endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Directed bench for rtc_multi_alarm: fast divider, short snooze/ring settings,
// expected snapshots queued as stimulus is driven and compared at the output.
module tb_rtc_multi_alarm;
  localparam int TICK_DIV   = 4;
  localparam int N_ALARM    = 4;
  localparam int SNOOZE_MIN = 5;
  localparam int RING_SEC   = 3;
  localparam int AW         = 2;
  localparam int W          = 25;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic         inc, dec;
  logic [AW-1:0] sel;
  logic         field, en_tgl, snooze, dismiss;
  logic [4:0]   hour, alm_hour;
  logic [5:0]   min, sec, alm_min;
  logic [3:0]   alm_en, ringing;
  logic         tick;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  rtc_multi_alarm #(
    .TICK_DIV(TICK_DIV), .N_ALARM(N_ALARM), .SNOOZE_MIN(SNOOZE_MIN),
    .RING_SEC(RING_SEC), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .inc(inc), .dec(dec), .sel(sel),
    .field(field), .en_tgl(en_tgl), .snooze(snooze), .dismiss(dismiss),
    .hour(hour), .min(min), .sec(sec), .alm_hour(alm_hour), .alm_min(alm_min),
    .alm_en(alm_en), .ringing(ringing), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                          input logic [3:0] r, input logic [3:0] e);
    exp_q.push_back({h, m, s, r, e});
  endtask

  task automatic check_snap(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    obs = {hour, min, sec, ringing, alm_en};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s no expected entry queued", tag);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s got %0d:%0d:%0d ring=%b en=%b expected %0d:%0d:%0d ring=%b en=%b", tag,
               obs[24:20], obs[19:14], obs[13:8], obs[7:4], obs[3:0],
               exp[24:20], exp[19:14], exp[13:8], exp[7:4], exp[3:0]);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                           input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if ({hour, min, sec} === {h, m, s}) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL %s timeout got %0d:%0d:%0d expected %0d:%0d:%0d", tag, hour, min, sec, h, m, s);
    end
  endtask

  task automatic adj(input bit up, input int n);
    repeat (n) begin
      if (up) inc = 1'b1; else dec = 1'b1;
      @(negedge clk);
      inc = 1'b0;
      dec = 1'b0;
    end
  endtask

  task automatic pulse_en(input logic [AW-1:0] ch);
    sel = ch;
    en_tgl = 1'b1;
    @(negedge clk);
    en_tgl = 1'b0;
  endtask

  task automatic pulse_snooze(input bit with_dismiss);
    snooze = 1'b1;
    dismiss = with_dismiss;
    @(negedge clk);
    snooze = 1'b0;
    dismiss = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; mode = 2'b00; inc = 1'b0; dec = 1'b0; sel = '0; field = 1'b0;
    en_tgl = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic set_alarm(input logic [AW-1:0] ch, input bit up, input int nh, input int nm);
    mode = 2'b11; sel = ch; field = 1'b0;
    adj(up, nh);
    field = 1'b1;
    adj(up, nm);
    field = 1'b0; mode = 2'b00;
  endtask

  task automatic set_time(input bit up, input int nh, input int nm);
    mode = 2'b01;
    adj(up, nh);
    mode = 2'b10;
    adj(up, nm);
    mode = 2'b00;
  endtask

  initial begin
    int tick_cnt;
    int tick_bad;

    // Reset values and divider/time advance.
    rst = 1'b1; mode = 2'b00; inc = 1'b0; dec = 1'b0; sel = '0; field = 1'b0;
    en_tgl = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    @(negedge clk);
    push_exp(0, 0, 0, 4'b0000, 4'b0000);
    check_snap("reset_state");
    check_val("reset_alarm_readout", {21'd0, alm_hour, alm_min}, 32'd0);
    check_val("reset_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick_cnt = 0;
    tick_bad = 0;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (tick) tick_cnt++;
      if (tick !== ((i % TICK_DIV) == TICK_DIV - 1)) tick_bad++;
    end
    check_val("tick_count", tick_cnt, 60);
    check_val("tick_phase_errors", tick_bad, 0);
    push_exp(0, 1, 0, 4'b0000, 4'b0000);
    check_snap("run_240");

    // 23:59:59 rolls over to midnight; hour and minute wrap downward on dec.
    do_reset();
    set_time(1'b0, 1, 1);
    wait_time(23, 59, 59, 300, "reach_235959");
    cycles(TICK_DIV);
    push_exp(0, 0, 0, 4'b0000, 4'b0000);
    check_snap("midnight_wrap");

    // Set-hour mode freezes time and clears seconds.
    do_reset();
    set_time(1'b1, 5, 10);
    wait_time(5, 10, 37, 200, "reach_051037");
    mode = 2'b01;
    cycles(20);
    push_exp(5, 10, 0, 4'b0000, 4'b0000);
    check_snap("set_freeze");
    adj(1'b0, 3);
    push_exp(2, 10, 0, 4'b0000, 4'b0000);
    check_snap("hour_dec3");
    inc = 1'b1; dec = 1'b1;
    @(negedge clk);
    inc = 1'b0; dec = 1'b0;
    push_exp(2, 10, 0, 4'b0000, 4'b0000);
    check_snap("inc_dec_same");
    mode = 2'b00;
    cycles(4 * TICK_DIV);
    push_exp(2, 10, 4, 4'b0000, 4'b0000);
    check_snap("resume_4_ticks");
    adj(1'b1, 1);
    cycles(TICK_DIV - 1);
    push_exp(2, 10, 5, 4'b0000, 4'b0000);
    check_snap("run_mode_adj_ignored");

    // Single alarm match, one clock latency, auto-clear after RING_SEC ticks.
    do_reset();
    set_alarm(2, 1'b1, 6, 30);
    pulse_en(2);
    check_val("alarm2_readout", {21'd0, alm_hour, alm_min}, {21'd0, 5'd6, 6'd30});
    sel = 1;
    #1;
    check_val("alarm1_readout", {21'd0, alm_hour, alm_min}, 32'd0);
    set_time(1'b1, 6, 29);
    wait_time(6, 30, 0, 300, "reach_0630");
    push_exp(6, 30, 0, 4'b0000, 4'b0100);
    check_snap("match_edge_not_yet");
    cycles(1);
    push_exp(6, 30, 0, 4'b0100, 4'b0100);
    check_snap("match_ring");
    cycles(3 * TICK_DIV - 2);
    push_exp(6, 30, 2, 4'b0100, 4'b0100);
    check_snap("ring_before_timeout");
    cycles(1);
    push_exp(6, 30, 3, 4'b0000, 4'b0100);
    check_snap("ring_auto_clear");

    // Two channels, snooze, re-ring, then dismiss beating snooze.
    do_reset();
    set_alarm(0, 1'b1, 7, 0);
    set_alarm(1, 1'b1, 7, 0);
    pulse_en(0);
    pulse_en(1);
    set_time(1'b1, 6, 59);
    wait_time(7, 0, 0, 300, "reach_0700");
    cycles(1);
    push_exp(7, 0, 0, 4'b0011, 4'b0011);
    check_snap("dual_ring");
    wait_time(7, 0, 2, 20, "reach_070002");
    pulse_snooze(1'b0);
    push_exp(7, 0, 2, 4'b0000, 4'b0011);
    check_snap("snooze_clears");
    wait_time(7, 5, 0, 1300, "reach_0705");
    cycles(1);
    push_exp(7, 5, 0, 4'b0011, 4'b0011);
    check_snap("snooze_rering");
    wait_time(7, 5, 1, 20, "reach_070501");
    pulse_snooze(1'b1);
    push_exp(7, 5, 1, 4'b0000, 4'b0011);
    check_snap("dismiss_and_snooze");
    wait_time(7, 10, 0, 1300, "reach_0710");
    cycles(1);
    push_exp(7, 10, 0, 4'b0000, 4'b0011);
    check_snap("dismiss_wins");

    // Snooze across midnight; disabling a ringing channel.
    do_reset();
    set_alarm(0, 1'b0, 1, 2);
    set_alarm(3, 1'b0, 1, 2);
    pulse_en(0);
    pulse_en(3);
    set_time(1'b0, 1, 3);
    wait_time(23, 58, 0, 300, "reach_2358");
    cycles(1);
    push_exp(23, 58, 0, 4'b1001, 4'b1001);
    check_snap("midnight_pair_ring");
    pulse_en(0);
    push_exp(23, 58, 0, 4'b1000, 4'b1000);
    check_snap("disable_clears_ring");
    wait_time(23, 58, 1, 20, "reach_235801");
    pulse_snooze(1'b0);
    push_exp(23, 58, 1, 4'b0000, 4'b1000);
    check_snap("snooze_2358");
    wait_time(0, 3, 0, 1300, "reach_0003");
    push_exp(0, 3, 0, 4'b0000, 4'b1000);
    check_snap("wrap_target_edge");
    cycles(1);
    push_exp(0, 3, 0, 4'b1000, 4'b1000);
    check_snap("wrap_target_ring");

    // Asynchronous reset between clock edges while ringing.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    push_exp(0, 0, 0, 4'b0000, 4'b0000);
    check_snap("async_reset");
    check_val("async_reset_tick", {31'd0, tick}, 32'd0);
    check_val("async_reset_alarm", {21'd0, alm_hour, alm_min}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(4 * TICK_DIV);
    push_exp(0, 0, 4, 4'b0000, 4'b0000);
    check_snap("resume_after_reset");

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
